// File: rtl/win_pkg.sv
// Shared defaults, FSM encoding and window count for the 3x3 window address generator.
// BORDER_CLAMP_EN selects full-image scan with edge replication.
package win_pkg;

  localparam int DEF_IMG_W     = 800;
  localparam int DEF_IMG_H     = 600;
  localparam int DEF_AW        = 19;
  localparam int DEF_CW        = 10;
  localparam int DEF_BASE_ADDR = 0;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t SCAN = 2'd1;
  localparam state_t DONE = 2'd2;

  function automatic int n_win(input int w, input int h);
`ifdef BORDER_CLAMP_EN
    return w * h;
`else
    return (w - 2) * (h - 2);
`endif
  endfunction

  localparam int N_WIN = n_win(DEF_IMG_W, DEF_IMG_H);

endpackage

// File: rtl/win_row_bases.sv
// Row-base registers for window rows r-1, r, r+1; shifted down one row per wrap.
// BORDER_CLAMP_EN replicates the first/last image row.
module win_row_bases
  import win_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int AW        = DEF_AW,
  parameter int CW        = DEF_CW,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          adv,
`ifdef BORDER_CLAMP_EN
  input  logic [CW-1:0] row,
`endif
  output logic [AW-1:0] b0,
  output logic [AW-1:0] b1,
  output logic [AW-1:0] b2
);

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] BASE_A = AW'(BASE_ADDR);

`ifdef BORDER_CLAMP_EN
  localparam logic [AW-1:0] L0 = BASE_A;
  localparam logic [AW-1:0] L1 = BASE_A;
  localparam logic [AW-1:0] L2 = (IMG_H > 1) ? BASE_A + W_A : BASE_A;

  // Entering the last row: r+1 stays clamped on that row.
  logic hold2;
  assign hold2 = (row == CW'(IMG_H - 2));
`else
  localparam logic [AW-1:0] L0 = BASE_A;
  localparam logic [AW-1:0] L1 = BASE_A + W_A;
  localparam logic [AW-1:0] L2 = BASE_A + W_A + W_A;

  logic hold2;
  assign hold2 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0 <= '0;
      b1 <= '0;
      b2 <= '0;
    end else if (load) begin
      b0 <= L0;
      b1 <= L1;
      b2 <= L2;
    end else if (adv) begin
      b0 <= b1;
      b1 <= b2;
      b2 <= hold2 ? b2 : b2 + W_A;
    end
  end

endmodule

// File: rtl/win3x3_addr_gen.sv
// Raster-scan 3x3 window address generator with valid/ready handshake.
// Optional BORDER_CLAMP_EN: scan every pixel, clamp neighbours to the edge.
module win3x3_addr_gen
  import win_pkg::*;
#(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int IMG_H     = DEF_IMG_H,
  parameter int AW        = DEF_AW,
  parameter int CW        = DEF_CW,
  parameter int BASE_ADDR = DEF_BASE_ADDR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          ready,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a0,
  output logic [AW-1:0] a1,
  output logic [AW-1:0] a2,
  output logic [AW-1:0] a3,
  output logic [AW-1:0] a4,
  output logic [AW-1:0] a5,
  output logic [AW-1:0] a6,
  output logic [AW-1:0] a7,
  output logic [AW-1:0] a8,
  output logic [AW-1:0] oa,
  output logic [CW-1:0] row,
  output logic [CW-1:0] col
);

  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [CW-1:0] ONE_C = CW'(1);

`ifdef BORDER_CLAMP_EN
  localparam logic [CW-1:0] R0     = '0;
  localparam logic [CW-1:0] C0     = '0;
  localparam logic [CW-1:0] R_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [AW-1:0] OA0    = '0;
  localparam logic [AW-1:0] OA_WRP = AW'(1);
`else
  localparam logic [CW-1:0] R0     = CW'(1);
  localparam logic [CW-1:0] C0     = CW'(1);
  localparam logic [CW-1:0] R_LAST = CW'(IMG_H - 2);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 2);
  localparam logic [AW-1:0] OA0    = AW'(IMG_W + 1);
  localparam logic [AW-1:0] OA_WRP = AW'(3);
`endif

  function automatic logic [AW-1:0] off_m(input logic [CW-1:0] c);
`ifdef BORDER_CLAMP_EN
    return (c == '0) ? AW'(c) : AW'(c) - ONE_A;
`else
    return AW'(c) - ONE_A;
`endif
  endfunction

  function automatic logic [AW-1:0] off_p(input logic [CW-1:0] c);
`ifdef BORDER_CLAMP_EN
    return (c == C_LAST) ? AW'(c) : AW'(c) + ONE_A;
`else
    return AW'(c) + ONE_A;
`endif
  endfunction

  state_t        state;
  logic [AW-1:0] cm, cp, cc;
  logic [AW-1:0] b0, b1, b2;
  logic          take, last, load, adv, col_step;
  logic [CW-1:0] nxt_col;

  always_comb begin
    take     = valid && ready;
    last     = (row == R_LAST) && (col == C_LAST);
    load     = (state == IDLE) && start;
    adv      = take && !last && (col == C_LAST);
    col_step = load || (take && !last);
    nxt_col  = col + ONE_C;
    if (load || col == C_LAST) nxt_col = C0;
  end

  win_row_bases #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW),
    .CW(CW), .BASE_ADDR(BASE_ADDR)
  ) u_rows (
    .clk(clk),
    .rst(rst),
    .load(load),
    .adv(adv),
`ifdef BORDER_CLAMP_EN
    .row(row),
`endif
    .b0(b0),
    .b1(b1),
    .b2(b2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      row   <= '0;
      col   <= '0;
      oa    <= '0;
      cm    <= '0;
      cp    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= SCAN;
          valid <= 1'b1;
          busy  <= 1'b1;
          row   <= R0;
          oa    <= OA0;
        end
        SCAN: if (take) begin
          if (last) begin
            state <= DONE;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (col == C_LAST) begin
            row <= row + ONE_C;
            oa  <= oa + OA_WRP;
          end else begin
            oa  <= oa + ONE_A;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (col_step) begin
        col <= nxt_col;
        cm  <= off_m(nxt_col);
        cp  <= off_p(nxt_col);
      end
    end
  end

  assign cc = AW'(col);

  assign a0 = b0 + cm;
  assign a1 = b0 + cc;
  assign a2 = b0 + cp;
  assign a3 = b1 + cm;
  assign a4 = b1 + cc;
  assign a5 = b1 + cp;
  assign a6 = b2 + cm;
  assign a7 = b2 + cc;
  assign a8 = b2 + cp;

endmodule

// File: tb/tb_win3x3_addr_gen.sv
// Bench for win3x3_addr_gen on a 10x6 image with BASE_ADDR=7.
// Follows BORDER_CLAMP_EN for expected scan range and clamping.
module tb_win3x3_addr_gen;

  localparam int W  = 10;
  localparam int H  = 6;
  localparam int AW = 19;
  localparam int CW = 10;
  localparam int BA = 7;

`ifdef BORDER_CLAMP_EN
  localparam int NW    = 60;
  localparam int F_A0  = 7;
  localparam int F_A2  = 8;
  localparam int F_A4  = 7;
  localparam int F_A8  = 18;
  localparam int F_OA  = 0;
  localparam int F_RC  = 0;
  localparam int WK    = 10;
  localparam int WK_A0 = 7;
  localparam int WK_OA = 10;
  localparam int L_A4  = 66;
  localparam int L_A8  = 66;
  localparam int L_OA  = 59;
`else
  localparam int NW    = 32;
  localparam int F_A0  = 7;
  localparam int F_A2  = 9;
  localparam int F_A4  = 18;
  localparam int F_A8  = 29;
  localparam int F_OA  = 11;
  localparam int F_RC  = 1;
  localparam int WK    = 8;
  localparam int WK_A0 = 17;
  localparam int WK_OA = 21;
  localparam int L_A4  = 55;
  localparam int L_A8  = 66;
  localparam int L_OA  = 48;
`endif

  logic          clk = 1'b0;
  logic          rst, start, ready;
  logic          valid, busy, done;
  logic [AW-1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, oa;
  logic [CW-1:0] row, col;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  win3x3_addr_gen #(
    .IMG_W(W), .IMG_H(H), .AW(AW), .CW(CW), .BASE_ADDR(BA)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .valid(valid), .busy(busy), .done(done),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4),
    .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .oa(oa), .row(row), .col(col)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [255:0] pack_out();
    return {valid, busy, a0, a1, a2, a3, a4, a5, a6, a7, a8, oa, row, col};
  endfunction

  function automatic logic [AW-1:0] ad(input int y, input int x);
    int yy, xx;
    yy = y;
    xx = x;
`ifdef BORDER_CLAMP_EN
    if (yy < 0) yy = 0;
    if (yy > H - 1) yy = H - 1;
    if (xx < 0) xx = 0;
    if (xx > W - 1) xx = W - 1;
`endif
    return AW'(BA + yy * W + xx);
  endfunction

  function automatic logic [255:0] exp_win(input int k);
    int r, c;
`ifdef BORDER_CLAMP_EN
    r = k / W;
    c = k % W;
`else
    r = 1 + k / (W - 2);
    c = 1 + k % (W - 2);
`endif
    return {1'b1, 1'b1,
            ad(r-1, c-1), ad(r-1, c), ad(r-1, c+1),
            ad(r,   c-1), ad(r,   c), ad(r,   c+1),
            ad(r+1, c-1), ad(r+1, c), ad(r+1, c+1),
            AW'(r * W + c), CW'(r), CW'(c)};
  endfunction

  task automatic run_scan(input bit rnd, input int rst_at,
                          input bit poke, input bit done_poke);
    int k, cyc;
    bit hold, got_done, aborted;
    logic [255:0] held;
    k = 0; cyc = 0; hold = 0; got_done = 0; aborted = 0; held = '0;
    ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_valid", valid, 1);
    check("lat_busy", busy, 1);
    while (!got_done && !aborted && cyc < 3000) begin
      if (rst_at >= 0 && k == rst_at) begin
        #2 rst = 1'b1;
        #1 check("async_rst", pack_out(), '0);
        check("rst_nodone", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("post_rst", {done, valid, busy}, 0);
        end
        aborted = 1;
      end else begin
        ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (hold) check("hold", pack_out(), held);
        start = poke && (k == 5);
        if (valid && ready) begin
          check("win", pack_out(), exp_win(k));
          if (k == 0) begin
            check("first_a0", a0, F_A0);
            check("first_a2", a2, F_A2);
            check("first_a4", a4, F_A4);
            check("first_a8", a8, F_A8);
            check("first_oa", oa, F_OA);
            check("first_rc", {row, col}, {CW'(F_RC), CW'(F_RC)});
          end
          if (k == WK) begin
            check("wrap_a0", a0, WK_A0);
            check("wrap_oa", oa, WK_OA);
          end
          if (k == NW - 1) begin
            check("last_a4", a4, L_A4);
            check("last_a8", a8, L_A8);
            check("last_oa", oa, L_OA);
          end
          k++;
          hold = 0;
        end else if (valid) begin
          held = pack_out();
          hold = 1;
        end else begin
          check("valid_drop", valid, 1);
        end
        @(negedge clk);
        cyc++;
        if (done) got_done = 1;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      check("done_seen", got_done, 1);
      check("count", k, NW);
      check("busy_in_done", {busy, valid}, 0);
      if (done_poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_1cyc", {done, valid}, 0);
      @(negedge clk);
      check("idle", {valid, busy, done}, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", pack_out(), '0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_start", {valid, busy, done}, 0);
    run_scan(1'b0, -1, 1'b0, 1'b1);
    run_scan(1'b1, -1, 1'b1, 1'b0);
    run_scan(1'b1, 10, 1'b0, 1'b0);
    run_scan(1'b0, -1, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
